// File: rtl/if_icache_fetch.sv
// Instruction fetch unit with a direct-mapped line cache refilled over a wide memory port.
// Optional feature macro: IF_ICACHE_EN builds the tag/data storage; without it every fetch refills.
module if_icache_fetch #(
  parameter int ADDR_W     = 17,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 32,
  localparam int LINE_W    = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              use_npc,
  input  logic [31:0]       npc_addr,
  input  logic [4:0]        stall,
  input  logic              flush,
  input  logic [LINE_W-1:0] ram_inst,
  input  logic              ram_inst_busy,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              ram_inst_re,
  output logic [31:0]       ram_inst_addr,
  output logic              stall_req,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W  = $clog2(4 * LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, REFILL, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc;
  logic [31:0]       inst_q, inst_d, addr_q, addr_d, hitCnt_q, hitCnt_d, missCnt_q, missCnt_d;
  logic              instValid_q, instValid_d, re_q, re_d, stallReq_q, stallReq_d;
  logic [IDX_W-1:0]  npcIdx, pcIdx;
  logic [TAG_W-1:0]  npcTag, pcTag;
  logic [WSEL_W-1:0] npcWord, pcWord;
  logic [31:0]       lineAddr, cachedWord;
  logic              hit, cacheWe, unusedBits;

  function automatic logic [31:0] pickWord(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] sel);
    pickWord = '0;
    for (int k = 0; k < LINE_WORDS; k++)
      if (sel == WSEL_W'(k)) pickWord = line[32*k +: 32];
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] v);
    satInc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign npc    = use_npc ? npc_addr[ADDR_W-1:0] : pc_q + ADDR_W'(4);
  assign npcIdx = npc[OFF_W+IDX_W-1:OFF_W];
  assign npcTag = npc[ADDR_W-1:OFF_W+IDX_W];
  assign pcIdx  = pc_q[OFF_W+IDX_W-1:OFF_W];
  assign pcTag  = pc_q[ADDR_W-1:OFF_W+IDX_W];

  generate
    if (LINE_WORDS > 1) begin : g_wsel
      assign npcWord = npc[OFF_W-1:2];
      assign pcWord  = pc_q[OFF_W-1:2];
    end else begin : g_nowsel
      assign npcWord = '0;
      assign pcWord  = '0;
    end
  endgenerate

  always_comb begin
    lineAddr = '0;
    lineAddr[ADDR_W-1:OFF_W] = npc[ADDR_W-1:OFF_W];
  end

`ifdef IF_ICACHE_EN
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // A flush in the lookup cycle must not let a stale line hit.
  assign hit        = valid_q[npcIdx] && (tag_q[npcIdx] == npcTag) && !flush;
  assign cachedWord = pickWord(data_q[npcIdx], npcWord);
  assign unusedBits = ^{stall[4:1], npc_addr};

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (rdy) begin
      if (flush)        valid_q <= '0;
      else if (cacheWe) valid_q[pcIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && cacheWe) begin
      tag_q[pcIdx]  <= pcTag;
      data_q[pcIdx] <= ram_inst;
    end
  end
`else
  assign hit        = 1'b0;
  assign cachedWord = '0;
  assign unusedBits = ^{stall[4:1], npc_addr, flush, cacheWe, npcIdx, npcTag, npcWord, pcIdx, pcTag};
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instValid_d = instValid_q;
    re_d        = re_q;
    stallReq_d  = stallReq_q;
    addr_d      = addr_q;
    hitCnt_d    = hitCnt_q;
    missCnt_d   = missCnt_q;
    cacheWe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stall[0]) begin
          pc_d   = npc;
          addr_d = lineAddr;
          if (hit) begin
            inst_d      = cachedWord;
            instValid_d = 1'b1;
            hitCnt_d    = satInc(hitCnt_q);
            state_d     = HOLD;
          end else begin
            inst_d      = '0;
            instValid_d = 1'b0;
            stallReq_d  = 1'b1;
            re_d        = 1'b1;
            missCnt_d   = satInc(missCnt_q);
            state_d     = REQ;
          end
        end
      end
      // Memory raises busy one cycle after the request, so REQ never looks at it.
      REQ: state_d = REFILL;
      REFILL: begin
        if (!ram_inst_busy) begin
          cacheWe     = !flush;
          inst_d      = pickWord(ram_inst, pcWord);
          instValid_d = 1'b1;
          re_d        = 1'b0;
          stallReq_d  = 1'b0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (!stall[0]) begin
          inst_d      = '0;
          instValid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= {{(ADDR_W-2){1'b1}}, 2'b00};
      inst_q      <= '0;
      instValid_q <= 1'b0;
      re_q        <= 1'b0;
      stallReq_q  <= 1'b0;
      addr_q      <= 32'hFFFF_FFFF;
      hitCnt_q    <= '0;
      missCnt_q   <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instValid_q <= instValid_d;
      re_q        <= re_d;
      stallReq_q  <= stallReq_d;
      addr_q      <= addr_d;
      hitCnt_q    <= hitCnt_d;
      missCnt_q   <= missCnt_d;
    end
  end

  assign pc            = pc_q;
  assign inst          = inst_q;
  assign inst_valid    = instValid_q;
  assign ram_inst_re   = re_q;
  assign ram_inst_addr = addr_q;
  assign stall_req     = stallReq_q;
  assign hit_cnt       = hitCnt_q;
  assign miss_cnt      = missCnt_q;

endmodule

// File: doc/if_icache_fetch.md
# if_icache_fetch

Parametrised instruction-fetch unit with a configurable direct-mapped instruction cache. It sits between the branch/redirect logic and the memory controller's instruction port. Each cycle it is not stalled, it selects the next PC, looks it up in the cache, and delivers one 32-bit instruction to decode. On a miss it raises `stall_req` and refills a whole line over the wide memory port. Beyond the previous generation it adds parametrised geometry, a cache-invalidate input, an explicit `inst_valid` flag, and hit/miss performance counters.

## Interface
- `ADDR_W`, 17: PC width in bits.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥1.
- `SETS`, 32: number of cache lines; power of two, ≥2.
- Derived widths:
  - `LINE_W` = 32·`LINE_WORDS`.
  - `OFF_W` = log2(4·`LINE_WORDS`).
  - `IDX_W` = log2(`SETS`).
  - `TAG_W` = `ADDR_W` − `IDX_W` − `OFF_W`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low (0 = reset).
- `rdy` in 1: global enable; when 0, all state and outputs freeze.
- `use_npc` in 1: take `npc_addr` instead of PC+4.
- `npc_addr` in 32: redirect target; bits [`ADDR_W`-1:0] are used.
- `stall` in 5: pipeline stall vector; only `stall[0]` is used.
- `flush` in 1: invalidate every cache line.
- `ram_inst` in `LINE_W`: refill line data; word k is at bits [32k+31:32k].
- `ram_inst_busy` in 1: memory refill still in progress.
- `pc` out `ADDR_W`: PC of the current fetch.
- `inst` out 32: fetched instruction; 0 when not valid.
- `inst_valid` out 1: `inst` holds a real instruction.
- `ram_inst_re` out 1: refill request.
- `ram_inst_addr` out 32: line-aligned refill address, zero-extended.
- `stall_req` out 1: requests a pipeline stall during a miss.
- `hit_cnt` out 32: saturating count of fetch hits.
- `miss_cnt` out 32: saturating count of fetch misses.

## Operation
- Reset values:
  - `pc` = −4 mod 2^`ADDR_W`.
  - `inst` = 0, `inst_valid` = 0.
  - `ram_inst_re` = 0, `stall_req` = 0.
  - `ram_inst_addr` = 32'hFFFFFFFF.
  - All valid bits = 0; counters = 0; state = IDLE.
- Address fields of npc:
  - npc = `use_npc` ? `npc_addr`[`ADDR_W`-1:0] : `pc`+4, wrapping modulo 2^`ADDR_W`.
  - index = npc[`OFF_W`+`IDX_W`-1:`OFF_W`].
  - tag = npc[`ADDR_W`-1:`OFF_W`+`IDX_W`].
  - word = npc[`OFF_W`-1:2]; bits [1:0] are ignored.
- IDLE:
  - If `stall[0]`=1: hold; no state or output change.
  - Otherwise: `pc` ← npc; `ram_inst_addr` ← npc with offset bits cleared.
  - Hit (line valid and tag equal): `inst` ← cached word, `inst_valid` ← 1, `hit_cnt`++, go to HOLD.
  - Miss: `inst` ← 0, `inst_valid` ← 0, `stall_req` ← 1, `ram_inst_re` ← 1, `miss_cnt`++, go to REQ.
- REQ: keep `ram_inst_re` and `stall_req` at 1; go to REFILL unconditionally. This absorbs memory's one-cycle delay before it asserts busy.
- REFILL:
  - While `ram_inst_busy`=1: hold `re` and `stall_req` at 1.
  - When `ram_inst_busy`=0:
    - Write the line at index(`pc`) with tag(`pc`) and valid = 1.
    - `inst` ← word(`pc`) of `ram_inst`; `inst_valid` ← 1.
    - `re` ← 0, `stall_req` ← 0; go to HOLD.
- HOLD:
  - If `stall[0]`=1: `inst`, `inst_valid` and `pc` are held.
  - Otherwise: `inst` ← 0, `inst_valid` ← 0; go to IDLE.
- Flush:
  - `flush`=1 clears all valid bits at that edge, in any state.
  - A lookup in the same cycle is forced to a miss.
  - A refill completing in the same cycle still delivers `inst` but does not write the line.
- `use_npc` is sampled only in IDLE with `stall[0]`=0. Redirects in other states are the pipeline's responsibility to hold.
- Both counters saturate at 32'hFFFFFFFF.
- `rst`=0 mid-refill returns to IDLE with reset values. Memory must drop any outstanding request when `ram_inst_re` falls.

## Timing
- Hit: IDLE at edge t, then `inst_valid`=1 after t+1. The next fetch issues at t+2 at the earliest. Throughput is one instruction per 2 cycles.
- Miss: IDLE at t, REQ at t+1, REFILL from t+2. `inst` is valid one edge after the first REFILL cycle that sees `ram_inst_busy`=0. Minimum latency is 3 cycles.
- `stall_req` and `ram_inst_re` are registered. They rise at the edge that leaves IDLE and fall at the edge that enters HOLD.
- `rdy`=0 freezes everything, including counters and the cache write. Memory holds `ram_inst` until the unit consumes it.

## Configuration
- `IF_ICACHE_EN` defined:
  - Cache storage is instantiated; behaviour is as above.
- `IF_ICACHE_EN` undefined:
  - No tag or data storage.
  - Every fetch misses and goes through REQ/REFILL.
  - `hit_cnt` stays 0; `flush` is ignored.
  - The refill write is omitted.

## Test plan
- Cold fetch: `rst`=0 for 2 cycles, then release; `stall`=0; memory busy for 3 cycles. Expect `pc`=0, `ram_inst_addr`=0 and `re`=1 from the issue edge. `inst` = word0 of the line with `inst_valid`=1 after busy drops; `miss_cnt`=1.
- Sequential hits: after the cold fetch, fetch 0x4, 0x8 and 0xC. Expect no `re`, 2 cycles per instruction, correct words 1–3, `hit_cnt`=3.
- Conflict (defaults): cache 0x0, then `use_npc` to 0x200 (index 0, tag 1). Expect a miss. Redirect back to 0x0: expect a miss again; `miss_cnt`=3.
- Flush: with line 0 cached, pulse `flush` in HOLD, then fetch 0x4. Expect a miss and `re`=1.
- Flush colliding with refill completion: then refetch the same address. Expect the instruction delivered once, then a miss on the refetch.
- Freeze: `stall[0]`=1 for 3 cycles in HOLD, then `rdy`=0 for 2 cycles in REFILL with busy=0. Expect `inst`, `pc` and counters unchanged. Completion occurs on the first `rdy`=1 edge.
